// File: rtl/itch_msg_serializer.sv
// itch_msg_serializer: record-to-ITCH 5.0 length-prefixed byte stream serializer; define ITCH_SER_TIMESTAMP_EN for a 48-bit cycle-count timestamp
module itch_msg_serializer #(
  parameter logic [15:0] STOCK_LOCATE = 16'h0000,
  parameter logic [7:0]  PAD_BYTE     = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] stock_id_i,
  input  logic [31:0] order_ref_num_i,
  input  logic [31:0] num_shares_i,
  input  logic [31:0] price_i,
  input  logic [3:0]  order_type_i,
  input  logic        buy_sell_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic        drop_o,
  output logic [15:0] seq_num_o
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [5:0] idx, last_idx;
  logic [7:0] tch_q;
  logic side_q;
  logic [31:0] ref_q, shares_q, stock_q, price_q;
  logic [47:0] ts_q;
  logic [15:0] len;
  logic [0:37][7:0] msg;
  logic acc, vt, hs, done;
`ifdef ITCH_SER_TIMESTAMP_EN
  logic [47:0] ts_cnt;
  always_ff @(posedge clk) begin
    ts_cnt <= !reset_n ? 48'h0 : ts_cnt + 48'd1;
    if (acc) ts_q <= ts_cnt;
  end
`else
  assign ts_q = 48'h0;
`endif
  assign vt = order_type_i == 4'h1 || order_type_i == 4'h4 || order_type_i == 4'h8;
  assign acc = valid_i && ready_o;
  assign hs = valid_o && ready_i;
  assign done = hs && last_o;
  assign ready_o = state == IDLE;
  assign valid_o = state == SEND;
  assign last_o = valid_o && idx == last_idx;
  assign data_o = valid_o ? msg[idx] : 8'h00;
  always_comb begin
    len = tch_q == 8'h41 ? 16'h0024 : tch_q == 8'h58 ? 16'h0017 : 16'h0013;
    last_idx = tch_q == 8'h41 ? 6'd37 : tch_q == 8'h58 ? 6'd24 : 6'd20;
    msg = {len, tch_q, STOCK_LOCATE, seq_num_o, ts_q, 32'h0, ref_q,
           tch_q == 8'h41 ? {side_q ? 8'h53 : 8'h42, shares_q, stock_q, {4{PAD_BYTE}}, price_q} :
           tch_q == 8'h58 ? {shares_q, 104'h0} : 136'h0};
    state_d = state == IDLE ? (acc && vt ? SEND : IDLE) : (done ? IDLE : SEND);
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      tch_q <= order_type_i == 4'h1 ? 8'h41 : order_type_i == 4'h4 ? 8'h58 : 8'h44;
      side_q <= buy_sell_i;
      ref_q <= order_ref_num_i;
      shares_q <= num_shares_i;
      stock_q <= stock_id_i;
      price_q <= price_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= 6'd0;
      drop_o <= 1'b0;
      seq_num_o <= 16'h0000;
    end else begin
      state <= state_d;
      idx <= acc || done ? 6'd0 : hs ? idx + 6'd1 : idx;
      drop_o <= acc && !vt;
      if (done) seq_num_o <= seq_num_o + 16'd1;
    end
  end
endmodule

// File: doc/itch_msg_serializer.md
Name: itch_msg_serializer

Overview:
Outbound counterpart of the ITCH byte-stream parser: accepts one decoded order record (stock id, order ref, shares, price, type, side) per handshake and emits a length-prefixed ITCH 5.0 message one byte per cycle. Used to generate order traffic toward the exchange/loopback path. It also drives the parser's `data_i`/`valid_i`/`ready_o` stream in self-test.

Parameters:
- `STOCK_LOCATE`, default `16'h0000`: constant stock-locate field written into every message.
- `PAD_BYTE`, default `8'h20`: fill for stock-symbol bytes 4..7, ASCII space.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `stock_id_i`  in  32: first 4 ASCII chars of the symbol, MSB first.
- `order_ref_num_i`  in  32: low 32 bits of the order reference.
- `num_shares_i`  in  32: shares. Used by A and X only.
- `price_i`  in  32: price. Used by A only.
- `order_type_i`  in  4: `4'h1`=ADD ('A'), `4'h4`=CANCEL ('X'), `4'h8`=DELETE ('D'). Any other value is invalid.
- `buy_sell_i`  in  1: 0=buy ('B' `8'h42`), 1=sell ('S' `8'h53`).
- `valid_i`  in  1: record valid.
- `ready_o`  out  1: serializer can accept a record.
- `data_o`  out  8: message byte.
- `valid_o`  out  1: `data_o` valid.
- `last_o`  out  1: final byte of the message.
- `ready_i`  in  1: downstream accepts the byte (backpressure).
- `drop_o`  out  1: one-cycle pulse when an invalid `order_type_i` is accepted.
- `seq_num_o`  out  16: tracking number that the next message will carry.

Behaviour:
- Reset values:
  - `ready_o=1`, `valid_o=0`, `last_o=0`, `data_o=8'h00`, `drop_o=0`, `seq_num_o=16'h0000`.
  - Timestamp counter = 0, state IDLE.
- States:
  - IDLE: `ready_o=1`. On `valid_i&&ready_o`, latch all inputs and the current `seq_num_o`.
    - Valid type: go to SEND.
    - Invalid type: pulse `drop_o` next cycle, stay IDLE, do not bump the sequence.
  - SEND: `ready_o=0`. `valid_o=1` from the cycle after acceptance. Byte index `idx` starts at 0.
    - `data_o`/`last_o` are held stable while `valid_o&&!ready_i`.
    - `idx` advances only on `valid_o&&ready_i`.
    - On the handshake where `last_o=1`: return to IDLE, deassert `valid_o`/`last_o`, increment `seq_num_o` (wraps `16'hFFFF`→`16'h0000`). `ready_o=1` the following cycle.
- Byte layout (idx: content, all multi-byte fields big-endian):
  - Common header:
    - 0–1: payload length, i.e. total bytes − 2.
    - 2: type char.
    - 3–4: `STOCK_LOCATE`.
    - 5–6: latched tracking number.
    - 7–12: 48-bit timestamp.
    - 13–16: `8'h00`.
    - 17–20: `order_ref_num`.
  - A (length `16'h0024`, 38 bytes total):
    - 21: side char.
    - 22–25: `num_shares`.
    - 26–29: `stock_id`.
    - 30–33: `PAD_BYTE`.
    - 34–37: `price`.
  - X (length `16'h0017`, 25 bytes total): 21–24: `num_shares`.
  - D (length `16'h0013`, 21 bytes total): ends at 20.
- Throughput:
  - Without backpressure, a message of N bytes occupies N+1 cycles from acceptance to the next `ready_o`.
  - First byte appears exactly 1 cycle after the input handshake.
- Timestamp: latched at input acceptance (see Optional Feature).
- Input changes while in SEND have no effect on the message in flight.
- Reset mid-message: abort immediately. All outputs go to reset values next cycle, with no partial-message completion.
- `drop_o` and `valid_o` are never high in the same cycle.

Optional Feature:
- Macro: `ITCH_SER_TIMESTAMP_EN`.
- Defined:
  - A free-running 48-bit cycle counter, reset to 0 and incremented every cycle, wrapping silently.
  - Its value at the input-handshake cycle fills bytes 7–12.
- Undefined: bytes 7–12 are `8'h00` and no counter is instantiated.

Test Plan:
1. ADD record, `ready_i=1`:
   - Stimulus: type `4'h1`, ref `32'hDEADBEEF`, buy, shares `32'h00001020`, stock `32'h000003E8`, price `32'h00002710`.
   - Response: 38 bytes `00 24 41 00 00 00 00 [ts×6] 00 00 00 00 DE AD BE EF 42 00 00 10 20 00 00 03 E8 20 20 20 20 00 00 27 10`.
   - `last_o` on byte 37; `seq_num_o` 0→1.
2. DELETE record, ref 936 → 21 bytes, length `00 13`, type `44`, bytes 17–20 `00 00 03 A8`, `last_o` on byte 20.
3. Sell ADD, stock `32'h41524758`, shares 600, price `32'h00105DD8`:
   - Byte 21 = `53`; bytes 22–25 = `00 00 02 58`; bytes 26–33 = `41 52 47 58 20 20 20 20`.
   - Loopback into the parser returns identical fields.
4. Backpressure: hold `ready_i=0` for 5 cycles at byte 10, toggle randomly elsewhere.
   - `data_o` stays stable while stalled; byte sequence is unchanged.
   - `ready_o=0` throughout the message, 1 after the last handshake.
5. `order_type_i=4'h0` with `valid_i=1` → accepted, `drop_o` pulses once, `valid_o` stays 0, `seq_num_o` unchanged.
6. Reset cases:
   - Assert `reset_n=0` at byte 15 of an ADD → next cycle `valid_o=0`, `ready_o=1`, `seq_num_o=0`; a following DELETE serializes correctly.
   - Preload 65535 messages (or force the counter) → tracking number `FF FF`, then `00 00`.
